// File: rtl/rr_mux_arbiter_5x1_pkg.sv
// Shared constants, state encoding and small helpers for the 5-to-1 round-robin
// arbiter/mux. Channel codes match the ones the 1x5 demux consumes.
package rr_mux_arbiter_5x1_pkg;

    localparam int N_CH  = 5;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] CH1 = 3'd0;
    localparam logic [SEL_W-1:0] CH2 = 3'd1;
    localparam logic [SEL_W-1:0] CH3 = 3'd2;
    localparam logic [SEL_W-1:0] CH4 = 3'd3;
    localparam logic [SEL_W-1:0] CH5 = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANTED = 2'd1,
        S_GAP     = 2'd2
    } state_t;

    // Channel index a+b, wrapping from CH5 back to CH1.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a,
                                                  input logic [SEL_W-1:0] b);
        logic [SEL_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (SEL_W+1)'(N_CH))
            s = s - (SEL_W+1)'(N_CH);
        return SEL_W'(s);
    endfunction

    function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] s);
        return N_CH'(1) << s;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_5x1_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping from channel 5 to channel 1.
module rr_pick5
    import rr_mux_arbiter_5x1_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] cand [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_cand
            assign cand[gi] = wrap_add(ptr, SEL_W'(gi));
        end
    endgenerate

    // Scan from the farthest candidate inward so the nearest requester wins.
    always_comb begin
        pick = CH1;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (req[cand[k]])
                pick = cand[k];
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter_5x1.sv
// 5-to-1 round-robin arbiter and data mux: grants one requester at a time,
// exports its encoded select and forwards its data bit one cycle later.
module rr_mux_arbiter_5x1
    import rr_mux_arbiter_5x1_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  Req,
    input  logic [N_CH-1:0]  Data,
    input  logic             Release,
    output logic [SEL_W-1:0] Sel,
    output logic [N_CH-1:0]  Grant,
    output logic             Valid,
    output logic             Out
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_CH-1:0]  grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             out_q, out_d;

    logic [SEL_W-1:0] pick;
    logic             any;
    logic             timeout_hit;

    rr_pick5 u_pick (
        .req  (Req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        out_d   = out_q;
        case (state_q)
            // The single GAP cycle also performs the idle arbitration on its
            // closing edge, so consecutive grants have exactly one dead cycle.
            S_IDLE, S_GAP: begin
                grant_d = '0;
                valid_d = 1'b0;
                out_d   = 1'b0;
                state_d = S_IDLE;
                if (any) begin
                    state_d = S_GRANTED;
                    sel_d   = pick;
                    grant_d = onehot(pick);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_GRANTED: begin
                if (Release || !Req[sel_q] || timeout_hit) begin
                    state_d = S_GAP;
                    grant_d = '0;
                    valid_d = 1'b0;
                    out_d   = 1'b0;
                    ptr_d   = (sel_q == CH5) ? CH1 : sel_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    out_d = Data[sel_q];
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= CH1;
            cnt_q   <= '0;
            sel_q   <= CH1;
            grant_q <= '0;
            valid_q <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign Sel   = sel_q;
    assign Grant = grant_q;
    assign Valid = valid_q;
    assign Out   = out_q;

endmodule

// File: tb/tb_rr_mux_arbiter_5x1.sv
// Directed bench for rr_mux_arbiter_5x1: expected output snapshots are queued
// as stimulus is driven and popped/compared once the DUT has produced them.
module tb_rr_mux_arbiter_5x1;
    import rr_mux_arbiter_5x1_pkg::*;

    logic             clk;
    logic             reset;
    logic [N_CH-1:0]  Req;
    logic [N_CH-1:0]  Data;
    logic             Release;
    logic [SEL_W-1:0] Sel;
    logic [N_CH-1:0]  Grant;
    logic             Valid;
    logic             Out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] sel;
        logic [N_CH-1:0]  grant;
        logic             out;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];

    rr_mux_arbiter_5x1 #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .Req     (Req),
        .Data    (Data),
        .Release (Release),
        .Sel     (Sel),
        .Grant   (Grant),
        .Valid   (Valid),
        .Out     (Out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input string tag, input logic v, input logic [SEL_W-1:0] s,
                              input logic [N_CH-1:0] g, input logic o);
        exp_t e;
        e.valid = v;
        e.sel   = s;
        e.grant = g;
        e.out   = o;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_now();
        exp_t  e;
        string t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (Valid === e.valid) else begin
                errors++;
                $error("FAIL %s valid: got %b expected %b", t, Valid, e.valid);
            end
            checks++;
            assert (Sel === e.sel) else begin
                errors++;
                $error("FAIL %s sel: got %b expected %b", t, Sel, e.sel);
            end
            checks++;
            assert (Grant === e.grant) else begin
                errors++;
                $error("FAIL %s grant: got %b expected %b", t, Grant, e.grant);
            end
            checks++;
            assert (Out === e.out) else begin
                errors++;
                $error("FAIL %s out: got %b expected %b", t, Out, e.out);
            end
            $display("t=%0t %s: valid=%b sel=%b grant=%b out=%b", $time, t, Valid, Sel, Grant, Out);
        end
    endtask

    // One clock: outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_now();
    endtask

    initial begin
        logic [SEL_W-1:0] nk;

        reset   = 1'b1;
        Req     = 5'b11111;
        Data    = 5'b00000;
        Release = 1'b0;
        #2;
        expect_out("reset_async", 1'b0, CH1, 5'b00000, 1'b0);
        check_now();
        expect_out("reset_held", 1'b0, CH1, 5'b00000, 1'b0);
        tick();
        expect_out("reset_held2", 1'b0, CH1, 5'b00000, 1'b0);
        tick();

        // First edge after reset release grants ch1.
        reset = 1'b0;
        expect_out("first_grant", 1'b1, CH1, 5'b00001, 1'b0);
        tick();

        // Full rotation with Release two cycles after each grant.
        for (int k = 0; k < 5; k++) begin
            nk = SEL_W'((k + 1) % 5);
            expect_out("rr_hold", 1'b1, SEL_W'(k), 5'b00001 << k, 1'b0);
            tick();
            Release = 1'b1;
            expect_out("rr_gap", 1'b0, SEL_W'(k), 5'b00000, 1'b0);
            tick();
            Release = 1'b0;
            expect_out("rr_next", 1'b1, nk, 5'b00001 << nk, 1'b0);
            tick();
        end
        Req     = 5'b00000;
        Release = 1'b1;
        expect_out("rr_end_gap", 1'b0, CH1, 5'b00000, 1'b0);
        tick();
        Release = 1'b0;
        expect_out("rr_end_idle", 1'b0, CH1, 5'b00000, 1'b0);
        tick();
        expect_out("idle_no_req", 1'b0, CH1, 5'b00000, 1'b0);
        tick();

        // Dropping the request ends the grant; pointer then skips past ch3.
        Req = 5'b00100;
        expect_out("ch3_grant", 1'b1, CH3, 5'b00100, 1'b0);
        tick();
        Req = 5'b00000;
        expect_out("ch3_drop_gap", 1'b0, CH3, 5'b00000, 1'b0);
        tick();
        Req = 5'b00101;
        expect_out("ptr3_picks_ch1", 1'b1, CH1, 5'b00001, 1'b0);
        tick();
        Release = 1'b1;
        Req     = 5'b00000;
        expect_out("ch1_release", 1'b0, CH1, 5'b00000, 1'b0);
        tick();
        Release = 1'b0;
        expect_out("idle_after_ch1", 1'b0, CH1, 5'b00000, 1'b0);
        tick();

        // Timeout: ch4 held with no release stays valid exactly 16 cycles.
        Req = 5'b01000;
        for (int k = 0; k < 16; k++) begin
            expect_out("timeout_valid", 1'b1, CH4, 5'b01000, 1'b0);
            tick();
        end
        expect_out("timeout_gap", 1'b0, CH4, 5'b00000, 1'b0);
        tick();
        expect_out("timeout_regrant", 1'b1, CH4, 5'b01000, 1'b0);
        tick();
        Req = 5'b00000;
        expect_out("ch4_drop_gap", 1'b0, CH4, 5'b00000, 1'b0);
        tick();
        expect_out("idle_after_ch4", 1'b0, CH4, 5'b00000, 1'b0);
        tick();

        // Data forwarding for ch2; other data bits must not leak through.
        Req = 5'b00010;
        expect_out("ch2_grant", 1'b1, CH2, 5'b00010, 1'b0);
        tick();
        Data = 5'b00010;
        expect_out("out_d1_1", 1'b1, CH2, 5'b00010, 1'b1);
        tick();
        Data = 5'b11101;
        expect_out("out_d1_0", 1'b1, CH2, 5'b00010, 1'b0);
        tick();
        Data = 5'b00010;
        expect_out("out_d1_1b", 1'b1, CH2, 5'b00010, 1'b1);
        tick();
        Data = 5'b10111;
        expect_out("out_others_toggle", 1'b1, CH2, 5'b00010, 1'b1);
        tick();
        Data    = 5'b11111;
        Release = 1'b1;
        Req     = 5'b00000;
        expect_out("out_zero_gap", 1'b0, CH2, 5'b00000, 1'b0);
        tick();
        Release = 1'b0;
        expect_out("out_zero_idle", 1'b0, CH2, 5'b00000, 1'b0);
        tick();

        // Asynchronous reset in the middle of a ch5 grant.
        Data = 5'b10000;
        Req  = 5'b10000;
        expect_out("ch5_grant", 1'b1, CH5, 5'b10000, 1'b0);
        tick();
        expect_out("ch5_out", 1'b1, CH5, 5'b10000, 1'b1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        expect_out("mid_reset_async", 1'b0, CH1, 5'b00000, 1'b0);
        check_now();
        Req = 5'b11111;
        expect_out("mid_reset_held", 1'b0, CH1, 5'b00000, 1'b0);
        tick();
        reset = 1'b0;
        expect_out("ptr_restart_ch1", 1'b1, CH1, 5'b00001, 1'b0);
        tick();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
